user_la_step_unit: RTL and testbench
====================================

// Module: user_la_step_unit
// PURPOSE
//  User-area test node driven by the management SoC over the logic analyzer (LA).
//  Firmware posts a step id, two GF(2^8) operands and an expected product, then pulses start.
//  The block computes the product bit-serially and compares it with the expected value.
//  It drives the step id on io[25:20] and {busy,err} on io[37:36]; 00 = step passed.
// PARAMETERS
//  STEP_W  6      width of step id (io[25:20])
//  POLY    8'h1B  low byte of the GF(2^8) reduction polynomial (x^8 implied, 0x11B)
//  NBITS   8      operand width = multiply iterations
// PORTS
//  wb_clk_i     in   1    single clock
//  wb_rst_i     in   1    reset, asynchronous, active-high
//  la_data_in   in   128  LA data from SoC
//  la_oenb      in   128  LA output-enable bar (0 = SoC drives that bit)
//  la_data_out  out  128  LA data to SoC
//  io_out       out  38   user IO outputs
//  io_oeb       out  38   user IO output-enable bar (0 = drive)
// BEHAVIOUR
//  LA map in: [5:0] step id; [6] start; [15:8] A; [23:16] B; [31:24] expected.
//  start_q = la_data_in[6] & ~la_oenb[6], registered once; start = rising edge of start_q.
//  On start with busy=0: latch step, A, B, expected; acc<=0; busy<=1; err<=0; cnt<=0.
//  start while busy=1: ignored entirely (step, operands, state unchanged).
//  Multiply, one iteration per cycle, MSB of B first:
//    acc <= xtime(acc) ^ (B[NBITS-1-cnt] ? A : 0); xtime(x) = {x[6:0],1'b0} ^ (x[7] ? POLY : 0).
//  After NBITS iterations (cycle 8 after the start edge): result<=acc, busy<=0,
//    err <= (acc != expected), done<=1.
//  Latency: busy high exactly NBITS cycles; result valid in the cycle busy falls.
//  done stays 1 until the next accepted start, which clears it.
//  err holds until the next accepted start.
//  Outputs:
//    io_out[25:20]=step; io_out[37]=busy; io_out[36]=err; all other io_out = 0.
//    io_oeb[37:36]=0, io_oeb[25:20]=0; all other io_oeb = 1.
//    la_data_out[7:0]=result, [8]=done, [9]=err, [10]=busy, [127:11]=0.
//  Reset (async assert, sync release): step=0, busy=0, err=0, done=0.
//    Also at reset: result=0, acc=0, cnt=0, start_q=0.
//    So io[25:20]=0 and io[37:36]=00 immediately after reset.
//  Reset mid-operation aborts the computation; no result or err is produced.
//  Step id is opaque: any 0..63 accepted; the same id may be repeated.
//  The block never self-advances the step.
// TESTING
//  1 Reset: assert wb_rst_i -> io[25:20]=0, io[37:36]=00, la_data_out=0.
//  2 step=1, A=0x57, B=0x83, exp=0xC1, pulse start -> io[37]=1 for 8 cycles.
//    Then io[37:36]=00, result=0xC1, io[25:20]=1.
//  3 step=2, A=0x02, B=0x87, exp=0x00 -> result=0x15, io[37:36]=01 (err).
//    Then step=3 with a correct exp -> err clears at start, 00 at end.
//  4 Start pulsed again while busy (step=5) -> ignored; io[25:20] keeps old step.
//    Result matches the first operands.
//  5 la_oenb[6]=1 while la_data_in[6] toggles -> no start, no state change.
//  6 Steps 1..16 sequentially, random A/B, exp = golden model.
//    Every step ends io[37:36]=00; io[25:20] tracks the step id.

Source files
------------

// File: rtl/user_la_step_unit.sv
// LA-driven GF(2^8) multiply/compare test node: firmware posts a step, operands and expected
// product, pulses start; the block reports {busy,err} and the step id on user IO.
module user_la_step_unit #(
  parameter int unsigned     STEP_W = 6,
  parameter logic [7:0]      POLY   = 8'h1B,
  parameter int unsigned     NBITS  = 8
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic [127:0] la_data_in,
  input  logic [127:0] la_oenb,
  output logic [127:0] la_data_out,
  output logic [37:0]  io_out,
  output logic [37:0]  io_oeb
);

  localparam int unsigned CntW = $clog2(NBITS);
  localparam logic [CntW-1:0] CntLast = CntW'(NBITS - 1);

  logic              start_q, start_prev_q, start_edge;
  logic              busy_q, err_q, done_q;
  logic [STEP_W-1:0] step_q;
  logic [NBITS-1:0]  a_q, b_q, exp_q, acc_q, result_q, acc_next;
  logic [CntW-1:0]   cnt_q;

  // Fields and enables the block does not use.
  logic unused_la;
  assign unused_la = ^{la_data_in[127:32], la_data_in[7], la_oenb[127:7], la_oenb[5:0]};

  assign start_edge = start_q & ~start_prev_q;

  // b_q shifts left every iteration, so its MSB is always the current multiplier bit.
  always_comb begin
    acc_next = {acc_q[NBITS-2:0], 1'b0} ^ (acc_q[NBITS-1] ? POLY : '0)
             ^ (b_q[NBITS-1] ? a_q : '0);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      start_q      <= 1'b0;
      start_prev_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
      step_q       <= '0;
      a_q          <= '0;
      b_q          <= '0;
      exp_q        <= '0;
      acc_q        <= '0;
      result_q     <= '0;
      cnt_q        <= '0;
    end else begin
      start_q      <= la_data_in[6] & ~la_oenb[6];
      start_prev_q <= start_q;
      if (start_edge && !busy_q) begin
        step_q <= la_data_in[STEP_W-1:0];
        a_q    <= la_data_in[8 +: NBITS];
        b_q    <= la_data_in[16 +: NBITS];
        exp_q  <= la_data_in[24 +: NBITS];
        acc_q  <= '0;
        cnt_q  <= '0;
        busy_q <= 1'b1;
        err_q  <= 1'b0;
        done_q <= 1'b0;
      end else if (busy_q) begin
        acc_q <= acc_next;
        b_q   <= b_q << 1;
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          result_q <= acc_next;
          busy_q   <= 1'b0;
          err_q    <= (acc_next != exp_q);
          done_q   <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    io_out                  = '0;
    io_out[20 +: STEP_W]    = step_q;
    io_out[37]              = busy_q;
    io_out[36]              = err_q;
    io_oeb                  = '1;
    io_oeb[37:36]           = 2'b00;
    io_oeb[20 +: STEP_W]    = '0;
    la_data_out             = '0;
    la_data_out[NBITS-1:0]  = result_q;
    la_data_out[8]          = done_q;
    la_data_out[9]          = err_q;
    la_data_out[10]         = busy_q;
  end

endmodule

// File: tb/tb_user_la_step_unit.sv
// Directed bench for user_la_step_unit: known GF(2^8) products, busy-ignore, gated start,
// mid-operation reset and a sequence of random steps against an independent multiply model.
module tb_user_la_step_unit;

  logic         clk;
  logic         rst;
  logic [127:0] la_data_in;
  logic [127:0] la_oenb;
  logic [127:0] la_data_out;
  logic [37:0]  io_out;
  logic [37:0]  io_oeb;

  int n_checks = 0;
  int n_fail   = 0;

  user_la_step_unit dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .la_data_in  (la_data_in),
    .la_oenb     (la_oenb),
    .la_data_out (la_data_out),
    .io_out      (io_out),
    .io_oeb      (io_oeb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // LSB-first shift-and-add with reduction by 0x11B.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p ^= x;
      if (x[7]) x = (x << 1) ^ 8'h1B;
      else      x = x << 1;
      y = y >> 1;
    end
    return p;
  endfunction

  // Returns at the first negedge after the accepting edge (busy already high).
  task automatic post(input logic [5:0] step, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] e);
    @(negedge clk);
    la_data_in[5:0]   = step;
    la_data_in[6]     = 1'b0;
    la_data_in[15:8]  = a;
    la_data_in[23:16] = b;
    la_data_in[31:24] = e;
    @(negedge clk);
    la_data_in[6] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    la_data_in[6] = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (io_out[37] && cycles < 20) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic check_end(input string tag, input logic [5:0] step, input logic [7:0] res,
                           input logic err);
    logic [37:0]  io_exp;
    logic [127:0] la_exp;
    io_exp          = '0;
    io_exp[25:20]   = step;
    io_exp[36]      = err;
    la_exp          = '0;
    la_exp[7:0]     = res;
    la_exp[8]       = 1'b1;
    la_exp[9]       = err;
    check({tag, "_io"}, io_out, io_exp);
    check({tag, "_la"}, la_data_out, la_exp);
  endtask

  initial begin
    logic [37:0] oeb_exp;
    int          cyc;
    logic [7:0]  a, b, p;
    logic        saw_busy;

    rst        = 1'b1;
    la_data_in = '0;
    la_oenb    = '0;
    oeb_exp          = '1;
    oeb_exp[37:36]   = 2'b00;
    oeb_exp[25:20]   = '0;

    // 1: reset state
    repeat (3) @(negedge clk);
    check("rst_io", io_out, 38'h0);
    check("rst_la", la_data_out, 128'h0);
    check("rst_oeb", io_oeb, oeb_exp);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_io", io_out, 38'h0);

    // 2: classic product 0x57*0x83 = 0xC1
    post(6'd1, 8'h57, 8'h83, 8'hC1);
    check("t2_busy_step", io_out[37:20], {2'b10, 10'b0, 6'd1});
    wait_done(cyc);
    check("t2_busy_cycles", cyc, 8);
    check_end("t2", 6'd1, 8'hC1, 1'b0);

    // 3: wrong expected value flags err, next correct step clears it
    post(6'd2, 8'h02, 8'h87, 8'h00);
    wait_done(cyc);
    check("t3a_busy_cycles", cyc, 8);
    check_end("t3a", 6'd2, 8'h15, 1'b1);
    post(6'd3, 8'h57, 8'h13, 8'hFE);
    check("t3b_err_cleared", io_out[37:36], 2'b10);
    check("t3b_done_cleared", la_data_out[8], 1'b0);
    wait_done(cyc);
    check_end("t3b", 6'd3, 8'hFE, 1'b0);

    // 4: start while busy is ignored
    post(6'd4, 8'h57, 8'h83, 8'hC1);
    @(negedge clk);
    la_data_in[5:0]   = 6'd5;
    la_data_in[15:8]  = 8'h02;
    la_data_in[23:16] = 8'h87;
    la_data_in[31:24] = 8'h15;
    la_data_in[6]     = 1'b1;
    @(negedge clk);
    @(negedge clk);
    la_data_in[6] = 1'b0;
    check("t4_step_held", io_out[25:20], 6'd4);
    wait_done(cyc);
    check_end("t4", 6'd4, 8'hC1, 1'b0);
    repeat (4) @(negedge clk);
    check("t4_no_restart", io_out[37], 1'b0);

    // 5: start gated by la_oenb[6]
    la_oenb[6] = 1'b1;
    saw_busy   = 1'b0;
    for (int i = 0; i < 12; i++) begin
      la_data_in[6] = i[0];
      @(negedge clk);
      if (io_out[37]) saw_busy = 1'b1;
    end
    la_data_in[6] = 1'b0;
    @(negedge clk);
    la_oenb[6] = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_no_busy", saw_busy, 1'b0);
    check_end("t5", 6'd4, 8'hC1, 1'b0);

    // reset mid-operation aborts everything
    post(6'd9, 8'hFF, 8'hFF, 8'h13);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_io", io_out, 38'h0);
    check("midrst_la", la_data_out, 128'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("midrst_after_io", io_out, 38'h0);
    check("midrst_after_la", la_data_out, 128'h0);

    // 6: steps 1..16 with random operands and model-computed expected value
    for (int s = 1; s <= 16; s++) begin
      a = 8'($urandom_range(255));
      b = 8'($urandom_range(255));
      p = gf_mul(a, b);
      post(6'(s), a, b, p);
      wait_done(cyc);
      check($sformatf("t6_%0d_cycles", s), cyc, 8);
      check_end($sformatf("t6_%0d", s), 6'(s), p, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
